axil_regbank: RTL and testbench

Parametrised AXI4-Lite slave register bank, the successor to the fixed four-register 32-bit packager slave. It provides NUM_REGS read/write registers of DATA_WIDTH bits with byte strobes, independent AW/W acceptance, registered read data and SLVERR for out-of-range addresses. The register contents are exported as a flat vector to downstream packager logic. It sits directly behind the interconnect master port, and the VIP master drives it in the block bench.

---
 rtl/axil_regbank_pkg.sv | 14 +
 rtl/axil_regbank_if.sv | 38 +++
 rtl/axil_regbank.sv | 168 ++++++++++++++++
 tb/tb_axil_regbank.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_regbank_pkg.sv
// Shared types and helpers for the AXI4-Lite register bank.
package axil_regbank_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } resp_e;

    // Byte-address bits below the word index.
    function automatic int unsigned addr_lsb(input int unsigned data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/axil_regbank_if.sv
// AXI4-Lite bus bundle between the interconnect master port and the register bank.
interface axil_regbank_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]              awprot;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [2:0]              arprot;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

endinterface

// File: rtl/axil_regbank.sv
// Parametrised AXI4-Lite register bank with byte strobes and SLVERR on out-of-range indices.
// Define AXIL_REGBANK_WPULSE_EN to add the per-register write-pulse output wr_pulse_o.
module axil_regbank
    import axil_regbank_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           ADDR_WIDTH = 8,
    parameter int unsigned           NUM_REGS   = 4,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
    input  logic                           ACLK,
    input  logic                           ARESETN,
    axil_regbank_if.slave                  bus,
`ifdef AXIL_REGBANK_WPULSE_EN
    output logic [NUM_REGS-1:0]            wr_pulse_o,
`endif
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);

    localparam int unsigned ADDR_LSB = addr_lsb(DATA_WIDTH);
    localparam int unsigned IDX_W    = ADDR_WIDTH - ADDR_LSB;
    localparam int unsigned STRB_W   = DATA_WIDTH / 8;

    function automatic logic [DATA_WIDTH-1:0] merge_strb(
        input logic [DATA_WIDTH-1:0] old_val,
        input logic [DATA_WIDTH-1:0] new_val,
        input logic [STRB_W-1:0]     strb
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_val;
        for (int b = 0; b < STRB_W; b++) begin
            if (strb[b]) res[b*8 +: 8] = new_val[b*8 +: 8];
        end
        return res;
    endfunction

    logic                               aw_full_q, w_full_q;
    logic [IDX_W-1:0]                   aw_idx_q;
    logic [DATA_WIDTH-1:0]              wdata_q;
    logic [STRB_W-1:0]                  wstrb_q;
    logic                               bvalid_q;
    resp_e                              bresp_q;
    logic                               rvalid_q;
    logic [DATA_WIDTH-1:0]              rdata_q;
    resp_e                              rresp_q;
    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_q, regs_d;
    logic [DATA_WIDTH-1:0]              rd_word;
    logic [IDX_W-1:0]                   ar_idx;
    logic aw_hs, w_hs, b_hs, ar_hs, r_hs, commit, aw_in_range, ar_in_range;
    logic unused_bits;

    // Readies are gated by ARESETN so they stay low while reset is held.
    assign bus.awready = ARESETN && !aw_full_q && !bvalid_q;
    assign bus.wready  = ARESETN && !w_full_q && !bvalid_q;
    assign bus.arready = ARESETN && !rvalid_q;
    assign bus.bvalid  = bvalid_q;
    assign bus.bresp   = bresp_q;
    assign bus.rvalid  = rvalid_q;
    assign bus.rdata   = rdata_q;
    assign bus.rresp   = rresp_q;

    assign aw_hs  = bus.awvalid && bus.awready;
    assign w_hs   = bus.wvalid && bus.wready;
    assign b_hs   = bvalid_q && bus.bready;
    assign ar_hs  = bus.arvalid && bus.arready;
    assign r_hs   = rvalid_q && bus.rready;
    assign commit = aw_full_q && w_full_q;

    assign ar_idx      = bus.araddr[ADDR_WIDTH-1:ADDR_LSB];
    assign aw_in_range = 32'(aw_idx_q) < NUM_REGS;
    assign ar_in_range = 32'(ar_idx) < NUM_REGS;

    assign unused_bits = ^{bus.awprot, bus.arprot, bus.awaddr[ADDR_LSB-1:0],
                           bus.araddr[ADDR_LSB-1:0]};

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (ar_idx == IDX_W'(i)) rd_word = regs_q[i];
        end
    end

    always_comb begin
        regs_d = regs_q;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (commit && aw_in_range && aw_idx_q == IDX_W'(i)) begin
                regs_d[i] = merge_strb(regs_q[i], wdata_q, wstrb_q);
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            regs_q <= {NUM_REGS{RESET_VAL}};
        end else begin
            regs_q <= regs_d;
        end
    end

    assign regs_o = regs_q;

    // Write path: AW and W fill their holding registers independently, commit when both full.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            aw_full_q <= 1'b0;
            aw_idx_q  <= '0;
            w_full_q  <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= OKAY;
        end else begin
            if (aw_hs) begin
                aw_full_q <= 1'b1;
                aw_idx_q  <= bus.awaddr[ADDR_WIDTH-1:ADDR_LSB];
            end
            if (w_hs) begin
                w_full_q <= 1'b1;
                wdata_q  <= bus.wdata;
                wstrb_q  <= bus.wstrb;
            end
            if (commit) begin
                aw_full_q <= 1'b0;
                w_full_q  <= 1'b0;
                bvalid_q  <= 1'b1;
                bresp_q   <= aw_in_range ? OKAY : SLVERR;
            end else if (b_hs) begin
                bvalid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= OKAY;
        end else if (ar_hs) begin
            rvalid_q <= 1'b1;
            rdata_q  <= ar_in_range ? rd_word : '0;
            rresp_q  <= ar_in_range ? OKAY : SLVERR;
        end else if (r_hs) begin
            rvalid_q <= 1'b0;
        end
    end

`ifdef AXIL_REGBANK_WPULSE_EN
    logic [NUM_REGS-1:0] wr_pulse_d, wr_pulse_q;

    always_comb begin
        wr_pulse_d = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (commit && aw_in_range && aw_idx_q == IDX_W'(i)) wr_pulse_d[i] = 1'b1;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wr_pulse_q <= '0;
        end else begin
            wr_pulse_q <= wr_pulse_d;
        end
    end

    assign wr_pulse_o = wr_pulse_q;
`endif

endmodule

// File: tb/tb_axil_regbank.sv
// Directed bench for axil_regbank: strobes, W-before-AW ordering, SLVERR, backpressure, reset.
module tb_axil_regbank;
    import axil_regbank_pkg::*;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 8;
    localparam int unsigned NR = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NR*DW-1:0]  regs;
    int                n_checks = 0;
    int                n_fail = 0;
    logic [1:0]        resp;
    logic [31:0]       rdat;
    logic [31:0]       hold_rdata;

`ifdef AXIL_REGBANK_WPULSE_EN
    logic [NR-1:0] wr_pulse;
    int            pulse_total = 0;
    int            pulse_mark;
    always @(posedge clk) pulse_total <= pulse_total + $countones(wr_pulse);
`endif

    always #5 clk = ~clk;

    axil_regbank_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    axil_regbank #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .NUM_REGS  (NR),
        .RESET_VAL ('0)
    ) dut (
        .ACLK      (clk),
        .ARESETN   (rst_n),
        .bus       (bus),
`ifdef AXIL_REGBANK_WPULSE_EN
        .wr_pulse_o(wr_pulse),
`endif
        .regs_o    (regs)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] r);
        bit aw_done = 0, w_done = 0, b_done = 0, aw_acc, w_acc, b_acc;
        int cyc = 0;
        r = 2'bxx;
        bus.awaddr = a; bus.awvalid = 1'b1;
        bus.wdata = d; bus.wstrb = s; bus.wvalid = 1'b1;
        while (!(aw_done && w_done) && cyc < 20) begin
            aw_acc = bus.awvalid && bus.awready;
            w_acc  = bus.wvalid && bus.wready;
            tick();
            cyc++;
            if (aw_acc) begin aw_done = 1; bus.awvalid = 1'b0; end
            if (w_acc)  begin w_done = 1;  bus.wvalid = 1'b0; end
        end
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        bus.bready = 1'b1;
        cyc = 0;
        while (!b_done && cyc < 20) begin
            b_acc = bus.bvalid;
            r = bus.bresp;
            tick();
            cyc++;
            if (b_acc) b_done = 1;
        end
        bus.bready = 1'b0;
        check("write_handshake", {aw_done, w_done, b_done}, 3'b111);
    endtask

    task automatic axi_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] r);
        bit ar_done = 0, r_done = 0, ar_acc, r_acc;
        int cyc = 0;
        d = 'x; r = 'x;
        bus.araddr = a; bus.arvalid = 1'b1;
        while (!ar_done && cyc < 20) begin
            ar_acc = bus.arready;
            tick();
            cyc++;
            if (ar_acc) begin ar_done = 1; bus.arvalid = 1'b0; end
        end
        bus.arvalid = 1'b0;
        bus.rready = 1'b1;
        cyc = 0;
        while (!r_done && cyc < 20) begin
            r_acc = bus.rvalid;
            d = bus.rdata;
            r = bus.rresp;
            tick();
            cyc++;
            if (r_acc) r_done = 1;
        end
        bus.rready = 1'b0;
        check("read_handshake", {ar_done, r_done}, 2'b11);
    endtask

    initial begin
        bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0; bus.bready = 1'b0;
        bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;

        // Reset state
        repeat (2) tick();
        check("rst_awready", bus.awready, 1'b0);
        check("rst_wready", bus.wready, 1'b0);
        check("rst_arready", bus.arready, 1'b0);
        check("rst_bvalid", bus.bvalid, 1'b0);
        check("rst_rvalid", bus.rvalid, 1'b0);
        check("rst_rdata", bus.rdata, 32'h0);
        check("rst_regs", regs, 128'h0);
        rst_n = 1'b1;
        #1;
        check("post_rst_readies", {bus.awready, bus.wready, bus.arready}, 3'b111);

        // Partial strobes over the reset value
        axi_write(8'h04, 32'hAABBCCDD, 4'b0101, resp);
        check("strb_bresp", resp, OKAY);
        check("strb_regs_o", regs[63:32], 32'h00BB00DD);
        axi_read(8'h04, rdat, resp);
        check("strb_rdata", rdat, 32'h00BB00DD);
        check("strb_rresp", resp, OKAY);

        // Basic write / readback of every register
        for (int i = 0; i < 4; i++) begin
            axi_write(8'(i * 4), 32'(i + 1), 4'hF, resp);
            check("wr_bresp", resp, OKAY);
        end
        for (int i = 0; i < 4; i++) begin
            axi_read(8'(i * 4), rdat, resp);
            check("rd_data", rdat, 32'(i + 1));
            check("rd_rresp", resp, OKAY);
        end
        check("regs_after_fill", regs, {32'h4, 32'h3, 32'h2, 32'h1});

        // W three cycles ahead of AW
`ifdef AXIL_REGBANK_WPULSE_EN
        pulse_mark = pulse_total;
`endif
        bus.wdata = 32'h5A5A5A5A; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        check("wfirst_wready_idle", bus.wready, 1'b1);
        tick();
        bus.wvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("wfirst_wready_held", bus.wready, 1'b0);
            check("wfirst_no_bvalid", bus.bvalid, 1'b0);
            tick();
        end
        check("wfirst_wready_held", bus.wready, 1'b0);
        bus.awaddr = 8'h08; bus.awvalid = 1'b1;
        tick();
        bus.awvalid = 1'b0;
        check("wfirst_bvalid_early", bus.bvalid, 1'b0);
        check("wfirst_reg_early", regs[95:64], 32'h3);
        tick();
        check("wfirst_bvalid", bus.bvalid, 1'b1);
        check("wfirst_bresp", bus.bresp, OKAY);
        check("wfirst_reg", regs[95:64], 32'h5A5A5A5A);
        bus.bready = 1'b1;
        tick();
        bus.bready = 1'b0;
        check("wfirst_b_done", bus.bvalid, 1'b0);
        check("wfirst_ready_again", {bus.awready, bus.wready}, 2'b11);
        tick();
        check("wfirst_single_commit", bus.bvalid, 1'b0);
`ifdef AXIL_REGBANK_WPULSE_EN
        check("wfirst_pulse_count", pulse_total - pulse_mark, 1);
`endif

        // Out-of-range accesses
`ifdef AXIL_REGBANK_WPULSE_EN
        pulse_mark = pulse_total;
`endif
        axi_write(8'h10, 32'hDEADBEEF, 4'hF, resp);
        check("oor_bresp", resp, SLVERR);
        check("oor_regs", regs, {32'h4, 32'h5A5A5A5A, 32'h2, 32'h1});
        axi_read(8'h10, rdat, resp);
        check("oor_rresp", resp, SLVERR);
        check("oor_rdata", rdat, 32'h0);
`ifdef AXIL_REGBANK_WPULSE_EN
        tick();
        check("oor_no_pulse", pulse_total - pulse_mark, 0);
`endif

        // Backpressure on B and R
        bus.awaddr = 8'h00; bus.wdata = 32'hCAFEF00D; bus.wstrb = 4'hF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        bus.araddr = 8'h0C; bus.arvalid = 1'b1;
        tick();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
        check("bp_rvalid", bus.rvalid, 1'b1);
        check("bp_rdata", bus.rdata, 32'h4);
        hold_rdata = bus.rdata;
        tick();
        check("bp_bvalid", bus.bvalid, 1'b1);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_hold_b", {bus.bvalid, bus.awready, bus.wready}, 3'b100);
            check("bp_hold_r", {bus.rvalid, bus.arready}, 2'b10);
            check("bp_hold_rdata", bus.rdata, hold_rdata);
        end
        bus.bready = 1'b1; bus.rready = 1'b1;
        tick();
        bus.bready = 1'b0; bus.rready = 1'b0;
        check("bp_release", {bus.bvalid, bus.rvalid, bus.awready, bus.arready}, 4'b0011);
        check("bp_reg0", regs[31:0], 32'hCAFEF00D);

        // Reset with only AW held
        bus.awaddr = 8'h00; bus.awvalid = 1'b1;
        tick();
        bus.awvalid = 1'b0;
        check("mid_aw_held", bus.awready, 1'b0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_readies", {bus.awready, bus.wready, bus.arready}, 3'b000);
        check("mid_rst_valids", {bus.bvalid, bus.rvalid}, 2'b00);
        check("mid_rst_resps", {bus.bresp, bus.rresp}, 4'b0000);
        check("mid_rst_rdata", bus.rdata, 32'h0);
        check("mid_rst_regs", regs, 128'h0);
        tick();
        rst_n = 1'b1;
        #1;
        check("mid_aw_discarded", bus.awready, 1'b1);
        bus.wdata = 32'h12345678; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        tick();
        bus.wvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("mid_w_only_no_b", bus.bvalid, 1'b0);
        end
        bus.awaddr = 8'h00; bus.awvalid = 1'b1;
        tick();
        bus.awvalid = 1'b0;
        tick();
        check("mid_bvalid", bus.bvalid, 1'b1);
        check("mid_bresp", bus.bresp, OKAY);
        check("mid_reg0", regs[31:0], 32'h12345678);
        bus.bready = 1'b1;
        tick();
        bus.bready = 1'b0;
        axi_read(8'h00, rdat, resp);
        check("mid_rdata", rdat, 32'h12345678);
        check("mid_rresp", resp, OKAY);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
